// File: rtl/pwm_duty_meter_pkg.sv
// pwm_duty_meter_pkg: definitions shared by the PWM duty meter and its divider.
//   state_t     - measurement FSM states
//   DUTY_STEPS  - duty resolution (result range 0..DUTY_STEPS)
//   DEF_CNT_W   - default counter width
//   DEF_TIMEOUT - default loss-of-signal timeout in clk cycles
package pwm_duty_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        LOST      = 2'd2
    } state_t;

    localparam int unsigned DUTY_STEPS  = 10;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 1000;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: repeated-subtraction divider producing a quotient in 0..DUTY_STEPS.
// Always runs DUTY_STEPS conditional-subtract cycles plus one finish cycle, so its
// occupancy is fixed regardless of the operands.
//   clk, rst     - clock, synchronous active-high reset
//   start        - load operands (ignored while busy)
//   abort        - drop the division in progress, no done pulse
//   numerator    - dividend
//   denominator  - divisor (must be non-zero)
//   busy         - division in progress
//   done         - combinational, high in the final busy cycle; quotient valid
//   quotient     - result, clamped to DUTY_STEPS
module pwm_duty_div
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned NUM_W = 20,
    parameter int unsigned DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             busy,
    output logic             done,
    output logic [3:0]       quotient
);

    localparam logic [3:0] LAST_STEP = 4'(DUTY_STEPS);
    localparam logic [3:0] MAX_QUO   = 4'(DUTY_STEPS);

    logic [NUM_W-1:0] rem_q;
    logic [NUM_W-1:0] den_q;
    logic [3:0]       quo_q;
    logic [3:0]       step_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            rem_q  <= numerator;
            den_q  <= NUM_W'(denominator);
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (step_q == LAST_STEP) begin
                busy_q <= 1'b0;
            end else begin
                step_q <= step_q + 4'd1;
                // Quotient limit doubles as the clamp to DUTY_STEPS.
                if (rem_q >= den_q && quo_q < MAX_QUO) begin
                    rem_q <= rem_q - den_q;
                    quo_q <= quo_q + 4'd1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == LAST_STEP);
    assign quotient = quo_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and duty (in tenths) of an async PWM input.
//   clk, rst     - clock, synchronous active-high reset
//   pwm_in       - asynchronous PWM input
//   duty_tenths  - rounded duty, 0..10
//   period       - last measured period in clk cycles (0 after loss of signal)
//   high_time    - last measured high time in clk cycles (0 after loss of signal)
//   meas_valid   - one-cycle pulse when the outputs above update
//   signal_lost  - no rising edge for TIMEOUT cycles
//   overrun      - sticky: a capture was dropped because the divider was busy
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [3:0]       duty_tenths,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             signal_lost,
    output logic             overrun
);

    localparam int unsigned     NUM_W     = CNT_W + 4;
    localparam int unsigned     IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               sync_ff1, synced, synced_prev;
    logic               rise, timeout, capture, div_start;
    logic [CNT_W-1:0]   period_cnt, high_cnt;
    logic [CNT_W-1:0]   hold_period, hold_high;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [NUM_W-1:0]   numerator;
    logic               div_busy, div_done;
    logic [3:0]         div_quo;

    assign rise      = synced & ~synced_prev;
    // An edge in the same cycle suppresses the timeout.
    assign timeout   = (state_q != LOST) && !rise && (idle_cnt == IDLE_LAST);
    assign capture   = (state_q == MEASURE) && rise;
    assign div_start = capture && !div_busy;
    // 10*high + period/2: rounds the quotient to nearest.
    assign numerator = (NUM_W'(high_cnt) << 3) + (NUM_W'(high_cnt) << 1)
                     + NUM_W'(period_cnt >> 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_EDGE: begin
                if (rise)         state_d = MEASURE;
                else if (timeout) state_d = LOST;
            end
            MEASURE: begin
                if (timeout)      state_d = LOST;
            end
            LOST: begin
                if (rise)         state_d = MEASURE;
            end
            default:              state_d = WAIT_EDGE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_EDGE;
            sync_ff1    <= 1'b0;
            synced      <= 1'b0;
            synced_prev <= 1'b0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            hold_period <= '0;
            hold_high   <= '0;
            idle_cnt    <= '0;
            duty_tenths <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            signal_lost <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_ff1    <= pwm_in;
            synced      <= sync_ff1;
            synced_prev <= synced;

            if (rise || timeout || state_q == LOST) idle_cnt <= '0;
            else                                    idle_cnt <= idle_cnt + 1'b1;

            // The edge cycle itself counts as the first cycle of the new period.
            if (rise) begin
                period_cnt <= CNT_W'(1);
                high_cnt   <= CNT_W'(1);
            end else if (state_q == MEASURE) begin
                if (period_cnt != CNT_MAX)           period_cnt <= period_cnt + 1'b1;
                if (synced && high_cnt != CNT_MAX)   high_cnt   <= high_cnt + 1'b1;
            end

            // Hold registers track only captures the divider accepted.
            if (div_start) begin
                hold_period <= period_cnt;
                hold_high   <= high_cnt;
            end
            if (capture && div_busy) overrun <= 1'b1;

            meas_valid <= 1'b0;
            if (timeout) begin
                signal_lost <= 1'b1;
                period      <= '0;
                high_time   <= '0;
                duty_tenths <= synced ? 4'(DUTY_STEPS) : 4'd0;
                meas_valid  <= 1'b1;
            end else if (div_done) begin
                duty_tenths <= div_quo;
                period      <= hold_period;
                high_time   <= hold_high;
                meas_valid  <= 1'b1;
            end

            if (state_q == LOST && rise) signal_lost <= 1'b0;
        end
    end

    pwm_duty_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .abort       (timeout),
        .numerator   (numerator),
        .denominator (period_cnt),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quo)
    );

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed checks of the PWM duty meter with hand-computed results.
module tb_pwm_duty_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [3:0]  duty_tenths;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        signal_lost;
    logic        overrun;

    int n_vec  = 0;
    int n_fail = 0;
    int mv_count = 0;
    int bad_duty = 0;
    bit duty_watch = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_meter #(
        .CNT_W   (16),
        .TIMEOUT (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .duty_tenths (duty_tenths),
        .period      (period),
        .high_time   (high_time),
        .meas_valid  (meas_valid),
        .signal_lost (signal_lost),
        .overrun     (overrun)
    );

    // Count published results away from the active edge.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            mv_count = mv_count + 1;
            if (duty_watch && duty_tenths != 4'd5) bad_duty = bad_duty + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm_run(input int per, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            tick(high);
            pwm_in = 1'b0;
            tick(per - high);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, ".duty"},   32'(duty_tenths), 32'd0);
        check_val({tag, ".period"}, 32'(period),      32'd0);
        check_val({tag, ".high"},   32'(high_time),   32'd0);
        check_val({tag, ".valid"},  32'(meas_valid),  32'd0);
        check_val({tag, ".lost"},   32'(signal_lost), 32'd0);
        check_val({tag, ".ovr"},    32'(overrun),     32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        check_zero_outputs("reset");
        rst = 1'b0;
        tick(2);

        // 20/10 steady: two published results after three rising edges
        mv_count = 0;
        pwm_run(20, 10, 3);
        check_val("p20.count",  32'(mv_count),    32'd2);
        check_val("p20.period", 32'(period),      32'd20);
        check_val("p20.high",   32'(high_time),   32'd10);
        check_val("p20.duty",   32'(duty_tenths), 32'd5);
        check_val("p20.ovr",    32'(overrun),     32'd0);

        // Rounding boundary: 13/40 -> 3, 14/40 -> 4
        pwm_run(40, 13, 2);
        check_val("h13.period", 32'(period),      32'd40);
        check_val("h13.high",   32'(high_time),   32'd13);
        check_val("h13.duty",   32'(duty_tenths), 32'd3);
        pwm_run(40, 14, 2);
        check_val("h14.period", 32'(period),      32'd40);
        check_val("h14.high",   32'(high_time),   32'd14);
        check_val("h14.duty",   32'(duty_tenths), 32'd4);

        // Loss of signal while held high
        pwm_run(20, 10, 3);
        pwm_in = 1'b1;
        tick(30);
        mv_count = 0;
        tick(470);
        check_val("los.early_lost", 32'(signal_lost), 32'd0);
        tick(600);
        check_val("los.lost",   32'(signal_lost), 32'd1);
        check_val("los.duty",   32'(duty_tenths), 32'd10);
        check_val("los.period", 32'(period),      32'd0);
        check_val("los.high",   32'(high_time),   32'd0);
        check_val("los.count",  32'(mv_count),    32'd1);
        pwm_in = 1'b0;
        tick(5);
        check_val("los.hold_lost", 32'(signal_lost), 32'd1);
        pwm_run(10, 5, 1);
        check_val("los.clear", 32'(signal_lost), 32'd0);

        // Period 10 overruns the divider; every published duty must still be 5
        mv_count   = 0;
        bad_duty   = 0;
        duty_watch = 1'b1;
        pwm_run(10, 5, 20);
        duty_watch = 1'b0;
        check_val("p10.ovr",      32'(overrun),        32'd1);
        check_val("p10.bad_duty", 32'(bad_duty),       32'd0);
        check_val("p10.some",     32'(mv_count >= 5),  32'd1);
        check_val("p10.lost",     32'(signal_lost),    32'd0);

        // Reset three cycles after a capture edge, using 20/4 so pwm is low at reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        pwm_run(20, 4, 3);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_zero_outputs("rst_mid");
        mv_count = 0;
        tick(14);
        pwm_run(20, 4, 1);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(2);
        check_val("rst_mid.quiet", 32'(mv_count), 32'd0);
        tick(14);
        check_val("rst_mid.count",  32'(mv_count),    32'd1);
        check_val("rst_mid.duty",   32'(duty_tenths), 32'd2);
        check_val("rst_mid.period", 32'(period),      32'd20);
        check_val("rst_mid.high",   32'(high_time),   32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 1000, number of clk cycles without a rising edge before loss of signal is declared.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-006 duty_tenths  output  4  measured duty cycle in 10% steps, range 0..10.
REQ-007 period  output  CNT_W  last measured period in clk cycles.
REQ-008 high_time  output  CNT_W  last measured high time in clk cycles.
REQ-009 meas_valid  output  1  one-cycle pulse when the outputs update.
REQ-010 signal_lost  output  1  high while no rising edge has been seen for TIMEOUT cycles.
REQ-011 overrun  output  1  sticky flag: a capture was discarded because the divider was busy.

Function
REQ-012 pwm_in SHALL pass through a 2-FF synchronizer; a rising edge SHALL be detected as synced=1 while the previous synced value=0.
REQ-013 FSM states SHALL be WAIT_EDGE, MEASURE and LOST.
- WAIT_EDGE: counters idle.
- MEASURE: period cycle count runs.
- LOST: timeout reached.
REQ-014 WAIT_EDGE -> MEASURE SHALL occur on the first rising edge; on that edge period_cnt=1, high_cnt=1, and nothing is captured.
REQ-015 In MEASURE, period_cnt SHALL increment every cycle; high_cnt SHALL increment while synced=1.
REQ-016 On each rising edge in MEASURE:
- capture period_cnt and high_cnt into hold registers;
- restart both counters at 1;
- start the divider if it is idle.
REQ-017 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 Divider result SHALL be duty_tenths = floor((10*high + period/2) / period), rounded to nearest.
- Computed by repeated subtraction, one subtraction per cycle.
- Numerator width CNT_W+4.
- Result SHALL clamp to 10.
REQ-019 meas_valid SHALL pulse in the cycle after the divider finishes; duty_tenths, period and high_time SHALL update in that same cycle.
- Total latency from capture edge to meas_valid is at most 12 cycles.
REQ-020 A capture that arrives while the divider is busy SHALL be discarded and SHALL set overrun; measurement SHALL continue.
REQ-021 Results SHALL be correct for every period of 12 cycles or more, with no overrun.
REQ-022 If no rising edge occurs for TIMEOUT consecutive cycles in WAIT_EDGE or MEASURE, the FSM SHALL enter LOST and, in that cycle:
- set signal_lost=1;
- set period=0, high_time=0;
- set duty_tenths=10 if synced=1, else 0;
- pulse meas_valid once.
REQ-023 In LOST, the outputs SHALL hold.
REQ-024 LOST -> MEASURE SHALL occur on the next rising edge: signal_lost clears and counting restarts as in REQ-014.
REQ-025 A division in progress when timeout fires SHALL be aborted, and its result SHALL NOT be published.
REQ-026 A rising edge and a timeout in the same cycle: the edge SHALL win.

Reset
REQ-027 rst SHALL set:
- state=WAIT_EDGE;
- synchronizer FFs, counters, hold registers and divider to 0 and idle;
- duty_tenths=0, period=0, high_time=0;
- meas_valid=0, signal_lost=0, overrun=0.
REQ-028 rst asserted mid-measurement or mid-division SHALL take priority over all other events, and no meas_valid SHALL follow from the interrupted work.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state typedef;
- DUTY_STEPS=10;
- the default CNT_W and TIMEOUT values.
REQ-030 The divider SHALL be a sub-module pwm_duty_div with handshake start/busy/done and inputs numerator/denominator.

Verification
REQ-031 Period 20, high 10, steady after reset -> after the second rising edge: meas_valid pulse, period=20, high_time=10, duty_tenths=5, overrun=0.
REQ-032 Period 40, high 13 -> duty_tenths=3; then high 14 -> duty_tenths=4 (rounding boundary at 3.5).
REQ-033 pwm_in held high for 1000 cycles after locking at period 20 -> signal_lost=1, duty_tenths=10, period=0, one meas_valid; the next rising edge clears signal_lost.
REQ-034 Period 10, high 5 -> some captures discarded, overrun=1; every published result has duty_tenths=5.
REQ-035 rst pulsed 3 cycles after a capture edge -> all outputs 0, no meas_valid for 2 edges, then normal results resume.
